// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default sizing constants and word type shared by the sync_fifo files
package sync_fifo_pkg;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] fifo_word_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_WIDTH storage with synchronous write and registered read ports
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // storage is deliberately never reset; only written entries are ever read
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  // read register holds its value between accepted reads and clears on reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags; SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] count;
  logic wr_en, rd_en;
  assign full = count == (ADDR_WIDTH+1)'(DEPTH);
  assign empty = count == '0;
  assign wr_en = write && !full;
  assign rd_en = read && !empty;
  // pointers wrap by natural overflow; count moves only when exactly one side is accepted
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (wr_en != rd_en) count <= wr_en ? count + (ADDR_WIDTH+1)'(1) : count - (ADDR_WIDTH+1)'(1);
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= overflow || (write && full);
      underflow <= underflow || (read && empty);
    end
`endif
  sync_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd_en(rd_en),
    .rd_addr(rd_ptr),
    .rd_data(data_out)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed checks of sync_fifo against a queue-based model
module tb_sync_fifo;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic write = 1'b0;
  logic read = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic full, empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow, underflow;
`endif
  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic [7:0] m_dout = '0;
  bit m_ovf = 0;
  bit m_unf = 0;
  logic [7:0] fill_vals [8] = '{8'h07, 8'h27, 8'h37, 8'h97, 8'h17, 8'h77, 8'h67, 8'hab};

  sync_fifo dut (
    .clk(clk),
    .reset(reset),
    .write(write),
    .read(read),
    .data_in(data_in),
    .data_out(data_out),
    .full(full),
    .empty(empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow(overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    bit wa, ra;
    write = w;
    read = r;
    data_in = d;
    @(posedge clk);
    wa = w && q.size() < DEPTH;
    ra = r && q.size() > 0;
    if (w && q.size() == DEPTH) m_ovf = 1;
    if (r && q.size() == 0) m_unf = 1;
    if (ra) m_dout = q.pop_front();
    if (wa) q.push_back(d);
    @(negedge clk);
    write = 1'b0;
    read = 1'b0;
    data_in = 'x;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #10;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h want 00", data_out); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_err: got %b%b want 00", overflow, underflow); end
`endif
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, fill_vals[i]);
      checks++; if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty[%0d]: got %b want 0", i, empty); end
      checks++; if (full !== (i == 7)) begin failures++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, i == 7); end
    end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b0, 8'hzz);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full: got %b want 1", full); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL ovf_dout: got %h want 00", data_out); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b want 1", overflow); end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      checks++; if (data_out !== fill_vals[i]) begin failures++; $display("FAIL drain_dout[%0d]: got %h want %h", i, data_out, fill_vals[i]); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL drain_full[%0d]: got %b want 0", i, full); end
      checks++; if (empty !== (i == 7)) begin failures++; $display("FAIL drain_empty[%0d]: got %b want %b", i, empty, i == 7); end
    end
    cycle(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'hab) begin failures++; $display("FAIL underflow_hold: got %h want ab", data_out); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL underflow_flag: got %b want 1", underflow); end
`endif
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 8'($urandom));
      checks++; if (data_out !== m_dout) begin failures++; $display("FAIL simul_dout[%0d]: got %h want %h", i, data_out, m_dout); end
      checks++; if (empty !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL simul_flags[%0d]: got e%b f%b want e0 f0", i, empty, full); end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      checks++; if (data_out !== m_dout) begin failures++; $display("FAIL simul_drain[%0d]: got %h want %h", i, data_out, m_dout); end
    end
  endtask

  task automatic test_empty_both();
    logic [7:0] held;
    held = m_dout;
    cycle(1'b1, 1'b1, 8'h5c);
    checks++; if (data_out !== held) begin failures++; $display("FAIL empty_both_hold: got %h want %h", data_out, held); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL empty_both_empty: got %b want 0", empty); end
    cycle(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h5c) begin failures++; $display("FAIL empty_both_read: got %h want 5c", data_out); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL empty_both_after: got %b want 1", empty); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'($urandom));
    cycle(1'b0, 1'b1, 8'h00);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL async_empty: got %b want 1", empty); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL async_dout: got %h want 00", data_out); end
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL async_read: got %h want 00", data_out); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL async_read_empty: got %b want 1", empty); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 1'($urandom), 8'($urandom));
      checks++; if (data_out !== m_dout) begin failures++; $display("FAIL rand_dout[%0d]: got %h want %h", i, data_out, m_dout); end
      checks++; if (full !== (q.size() == DEPTH)) begin failures++; $display("FAIL rand_full[%0d]: got %b want %b", i, full, q.size() == DEPTH); end
      checks++; if (empty !== (q.size() == 0)) begin failures++; $display("FAIL rand_empty[%0d]: got %b want %b", i, empty, q.size() == 0); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      checks++; if (overflow !== m_ovf || underflow !== m_unf) begin failures++; $display("FAIL rand_err[%0d]: got %b%b want %b%b", i, overflow, underflow, m_ovf, m_unf); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_empty_both();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
